// File: rtl/reg_word_serializer_pkg.sv
// Shared types and sizing helpers for the register word serializer family.
package reg_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CHK
  } state_t;

  function automatic int nwords(input int width, input int word);
    return width / word;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_word_serializer_if.sv
// Word stream valid/ready interface for the register word serializer.
interface reg_word_serializer_if #(
  parameter int WORD = 16
);

  logic [WORD-1:0] Word_Out;
  logic            Word_Valid;
  logic            Word_Ready;

  modport master (
    output Word_Out,
    output Word_Valid,
    input  Word_Ready
  );

  modport slave (
    input  Word_Out,
    input  Word_Valid,
    output Word_Ready
  );

endinterface

// File: rtl/reg_word_serializer.sv
// Captures a WIDTH-bit value and streams it LS word first over valid/ready.
// Define SERIAL_CHECKSUM_EN to append one XOR checksum word to each stream.
module reg_word_serializer
  import reg_serial_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int WORD  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [WIDTH-1:0]       Data_In,
  reg_word_serializer_if.master  stream,
  output logic                   Busy,
  output logic                   Done
);

  localparam int NWORDS = nwords(WIDTH, WORD);
  localparam int CW     = cnt_w(NWORDS);

  if (WIDTH % WORD != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of WORD");
  end

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    idx;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_CHECKSUM_EN
  logic [WORD-1:0]  csum;
`endif

  logic xfer;
  logic last;

  assign xfer = valid_q && stream.Word_Ready;
  assign last = (idx == CW'(NWORDS - 1));

  assign stream.Word_Out   = sreg[WORD-1:0];
  assign stream.Word_Valid = valid_q;
  assign Busy              = busy_q;
  assign Done              = done_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      sreg    <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            sreg    <= Data_In;
            idx     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SEND;
`ifdef SERIAL_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        SEND: begin
          if (xfer) begin
            idx <= idx + 1'b1;
`ifdef SERIAL_CHECKSUM_EN
            csum <= csum ^ sreg[WORD-1:0];
            if (last) begin
              // checksum word is presented through the low slice
              sreg  <= WIDTH'(csum ^ sreg[WORD-1:0]);
              state <= CHK;
            end else begin
              sreg <= sreg >> WORD;
            end
`else
            sreg <= sreg >> WORD;
            if (last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end
`endif
          end
        end
        CHK: begin
          if (xfer) begin
            sreg    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_word_serializer.sv
// Directed self-checking bench for reg_word_serializer (WIDTH=64, WORD=16).
module tb_reg_word_serializer;

`ifdef SERIAL_CHECKSUM_EN
  localparam int NEXP = 5;
`else
  localparam int NEXP = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] data = '0;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_w [5];

  reg_word_serializer_if #(.WORD(16)) bus ();

  reg_word_serializer #(
    .WIDTH(64),
    .WORD (16)
  ) dut (
    .Clk    (clk),
    .Reset  (rst_n),
    .Start  (start),
    .Data_In(data),
    .stream (bus.master),
    .Busy   (busy),
    .Done   (done)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Word_Ready = 1'b1;
    tick();
    n_chk++;
    if ({bus.Word_Valid, busy, done} !== 3'b000 || bus.Word_Out !== 16'h0) begin
      n_err++;
      $display("FAIL reset: v/b/d=%b%b%b out=%h want 000/0000",
               bus.Word_Valid, busy, done, bus.Word_Out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    data  = 64'h1234_5678_0000_0000;
    start = 1'b1;
    bus.Word_Ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NEXP; i++) begin
      n_chk++;
      if (bus.Word_Valid !== 1'b1 || busy !== 1'b1 || bus.Word_Out !== exp_w[i]) begin
        n_err++;
        $display("FAIL basic word%0d: v=%b b=%b out=%h want 1/1/%h",
                 i, bus.Word_Valid, busy, bus.Word_Out, exp_w[i]);
      end
      tick();
    end
    n_chk++;
    if ({done, busy, bus.Word_Valid} !== 3'b100) begin
      n_err++;
      $display("FAIL basic done: d/b/v=%b%b%b want 100", done, busy, bus.Word_Valid);
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_ready_toggle();
    logic [3:0] pat;
    int k;
    bit seen;
    bit acc;
    pat  = 4'b1001;
    k    = 0;
    seen = 1'b0;
    data  = 64'h1234_5678_0000_0000;
    start = 1'b1;
    bus.Word_Ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.Word_Valid === 1'b1) begin
        n_chk++;
        if (k >= NEXP || bus.Word_Out !== exp_w[k % 5]) begin
          n_err++;
          $display("FAIL toggle word%0d: out=%h want %h", k, bus.Word_Out, exp_w[k % 5]);
        end
      end
      bus.Word_Ready = pat[c % 4];
      acc = (bus.Word_Valid === 1'b1) && bus.Word_Ready;
      tick();
      if (acc) k++;
      if (done === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen || k != NEXP) begin
      n_err++;
      $display("FAIL toggle count: done_seen=%0d words=%0d want 1/%0d", seen, k, NEXP);
    end
    bus.Word_Ready = 1'b1;
    tick();
  endtask

  task automatic test_busy_ignore();
    data  = 64'h1234_5678_0000_0000;
    start = 1'b1;
    bus.Word_Ready = 1'b1;
    tick();
    data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < NEXP; i++) begin
      start = (i < 2);
      n_chk++;
      if (bus.Word_Valid !== 1'b1 || bus.Word_Out !== exp_w[i]) begin
        n_err++;
        $display("FAIL busy_ignore word%0d: v=%b out=%h want 1/%h",
                 i, bus.Word_Valid, bus.Word_Out, exp_w[i]);
      end
      tick();
    end
    start = 1'b0;
    n_chk++;
    if ({done, busy, bus.Word_Valid} !== 3'b100) begin
      n_err++;
      $display("FAIL busy_ignore end: d/b/v=%b%b%b want 100", done, busy, bus.Word_Valid);
    end
    tick();
    n_chk++;
    if ({busy, bus.Word_Valid} !== 2'b00) begin
      n_err++;
      $display("FAIL busy_ignore idle: b/v=%b%b want 00", busy, bus.Word_Valid);
    end
  endtask

  task automatic test_mid_reset();
    data  = 64'h1234_5678_0000_0000;
    start = 1'b1;
    bus.Word_Ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.Word_Valid, busy, done} !== 3'b000 || bus.Word_Out !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset async: v/b/d=%b%b%b out=%h want 000/0000",
               bus.Word_Valid, busy, done, bus.Word_Out);
    end
    tick();
    n_chk++;
    if ({bus.Word_Valid, busy} !== 2'b00 || bus.Word_Out !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset held: v/b=%b%b out=%h want 00/0000",
               bus.Word_Valid, busy, bus.Word_Out);
    end
    rst_n = 1'b1;
    tick();
    data  = 64'hAAAA_BBBB_CCCC_DDDD;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (bus.Word_Valid !== 1'b1 || bus.Word_Out !== 16'hDDDD) begin
      n_err++;
      $display("FAIL mid_reset restart w0: v=%b out=%h want 1/dddd",
               bus.Word_Valid, bus.Word_Out);
    end
    tick();
    n_chk++;
    if (bus.Word_Out !== 16'hCCCC) begin
      n_err++;
      $display("FAIL mid_reset restart w1: out=%h want cccc", bus.Word_Out);
    end
    for (int i = 0; i < NEXP; i++) tick();
  endtask

  task automatic test_back_to_back();
    data  = 64'h1234_5678_0000_0000;
    start = 1'b1;
    bus.Word_Ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NEXP; i++) tick();
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b done: d/b=%b%b want 10", done, busy);
    end
    data  = 64'h0000_0000_0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (bus.Word_Valid !== 1'b1 || busy !== 1'b1 || bus.Word_Out !== 16'h0001) begin
      n_err++;
      $display("FAIL b2b restart: v=%b b=%b out=%h want 1/1/0001",
               bus.Word_Valid, busy, bus.Word_Out);
    end
    for (int i = 0; i < NEXP; i++) tick();
    n_chk++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b second done: done=%b want 1", done);
    end
    tick();
  endtask

  initial begin
    exp_w[0] = 16'h0000;
    exp_w[1] = 16'h0000;
    exp_w[2] = 16'h5678;
    exp_w[3] = 16'h1234;
    exp_w[4] = 16'h444C;
    bus.Word_Ready = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
